prog_mem_ctrl: RTL and testbench
================================

PROG_MEM_CTRL -- requirements
Module: prog_mem_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE, 16'd50000, cycles button must be stable low to register a press.
REQ-002 SHALL have parameter TIMEOUT, 20'd100000, max cycles allowed between a low byte and its high byte.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports button  input  1  raw, asynchronous, active-low mode-toggle pushbutton.
REQ-006 SHALL have ports rx_valid  input  1 and rx_data  input  8: one-cycle strobe plus byte from the UART receiver.
REQ-007 SHALL have port addrPC  input  8  CPU fetch address.
REQ-008 SHALL have ports mem_we  output  1, mem_addr  output  8 and mem_wdata  output  16: single program-RAM port.
REQ-009 SHALL have port mode  output  1  0 = load, 1 = run.
REQ-010 SHALL have ports words_loaded  output  9, full  output  1 and err_timeout  output  1.

Function
REQ-011 SHALL implement FSM states LOAD_LO, LOAD_HI, WRITE and RUN.
REQ-012 LOAD_LO: on rx_valid, latch rx_data as low byte and go to LOAD_HI.
REQ-013 LOAD_HI: on rx_valid, latch rx_data as high byte and go to WRITE.
REQ-014 LOAD_HI: count cycles; after TIMEOUT cycles with no byte, discard the low byte, set err_timeout and return to LOAD_LO.
REQ-015 WRITE SHALL last exactly 1 cycle, with mem_we=1, mem_addr=wr_ptr and mem_wdata={hi,lo}.
REQ-016 WRITE SHALL then increment wr_ptr and words_loaded, and return to LOAD_LO.
REQ-017 Write latency: mem_we SHALL assert on the cycle after the high-byte rx_valid cycle.
REQ-018 On the write with wr_ptr=8'hFF, full SHALL set and wr_ptr SHALL wrap to 0.
REQ-019 While full=1, rx bytes SHALL be ignored and no further writes SHALL occur.
REQ-020 words_loaded SHALL saturate at 256.
REQ-021 In RUN: mem_we=0, mem_addr=addrPC combinationally, mem_wdata don't-care, rx_valid ignored.
REQ-022 In all load states except WRITE: mem_we=0 and mem_addr=wr_ptr.
REQ-023 mode SHALL be 1 only in RUN.
REQ-024 Button path: 2-FF synchronizer, then a debounce counter.
REQ-025 A press event SHALL be one pulse when the synced button has been low for DEBOUNCE consecutive cycles.
REQ-026 Button release (high for DEBOUNCE consecutive cycles) SHALL re-arm the press detector; holding SHALL yield only one event.
REQ-027 Press in any load state SHALL go to RUN, discarding any partial low byte; a press in WRITE SHALL first complete the write.
REQ-028 Press in RUN SHALL go to LOAD_LO and clear wr_ptr, words_loaded, full and err_timeout.
REQ-029 If rx_valid and a press event occur in the same cycle, the press SHALL take priority and the byte SHALL be dropped.
REQ-030 err_timeout SHALL be sticky until reset or RUN->load transition; the next accepted low byte SHALL not clear it.

Reset
REQ-031 Asynchronous reset SHALL force state LOAD_LO and mode=0.
REQ-032 Asynchronous reset SHALL set mem_we=0, mem_addr=0, mem_wdata=0, words_loaded=0, full=0 and err_timeout=0.
REQ-033 Asynchronous reset SHALL clear wr_ptr, the byte latches, the synchronizer (to 1) and the debounce counters.
REQ-034 Reset mid-operation (e.g. in LOAD_HI or WRITE) SHALL abort without issuing mem_we.

Structure
REQ-035 State encodings, ADDR_W=8, DATA_W=16 and default DEBOUNCE/TIMEOUT SHALL live in shared package cpu_pkg.
REQ-036 Button synchronizer plus debounce SHALL be sub-module btn_debounce (clk, reset, btn_n, press).
REQ-037 Implementation SHALL be 120-400 lines of RTL.

Verification (DEBOUNCE=5, TIMEOUT=1000 in bench)
REQ-038 Send 0x0B, 0x13 then 0x00, 0x0E -> mem_we pulses with (addr 0, 16'h130B) then (addr 1, 16'h0E00); words_loaded=2.
REQ-039 Button low 10 cycles -> mode=1 after sync+DEBOUNCE; addrPC=1 -> mem_addr=1, mem_we never asserts in RUN.
REQ-040 Send 0x55, then idle 1000 cycles -> err_timeout=1, no write; then 0x34, 0x12 -> write 16'h1234 at the current wr_ptr.
REQ-041 Send 256 words -> full=1 after the 256th, words_loaded=256; 257th word -> no mem_we.
REQ-042 Press in LOAD_HI, plus a press coincident with rx_valid -> partial byte dropped, mode=1, no write.
REQ-043 Assert reset mid-LOAD_HI -> all outputs return to reset values with no write.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the program-memory loader: FSM encoding, bus widths
// and default timing parameters.
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 9;

    localparam logic [15:0] DEF_DEBOUNCE = 16'd50000;
    localparam logic [19:0] DEF_TIMEOUT  = 20'd100000;

    typedef enum logic [1:0] {
        LOAD_LO = 2'd0,
        LOAD_HI = 2'd1,
        WRITE   = 2'd2,
        RUN     = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce for an active-low pushbutton; emits a
// single-cycle press pulse per stable press, re-armed by a stable release.
module btn_debounce
    import cpu_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int SYNC_STAGES = 2;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [15:0]            low_cnt_reg;
    logic [15:0]            high_cnt_reg;
    logic                   armed_reg;
    logic                   btn_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_reg[0] <= 1'b1;
        else       sync_reg[0] <= btn_n;
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or posedge reset) begin
                if (reset) sync_reg[gi] <= 1'b1;
                else       sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    endgenerate

    assign btn_s = sync_reg[SYNC_STAGES-1];

    // Counters saturate at DEBOUNCE-1 so a long hold never wraps into a second event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_cnt_reg  <= 16'd0;
            high_cnt_reg <= 16'd0;
        end else if (btn_s) begin
            low_cnt_reg <= 16'd0;
            if (high_cnt_reg != DEBOUNCE - 16'd1)
                high_cnt_reg <= high_cnt_reg + 16'd1;
        end else begin
            high_cnt_reg <= 16'd0;
            if (low_cnt_reg != DEBOUNCE - 16'd1)
                low_cnt_reg <= low_cnt_reg + 16'd1;
        end
    end

    assign press = armed_reg && !btn_s && (low_cnt_reg == DEBOUNCE - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            armed_reg <= 1'b1;
        else if (press)
            armed_reg <= 1'b0;
        else if (btn_s && (high_cnt_reg == DEBOUNCE - 16'd1))
            armed_reg <= 1'b1;
    end

endmodule

// File: rtl/prog_mem_ctrl.sv
// Program-RAM loader: assembles UART byte pairs into 16-bit words, writes them
// sequentially, and hands the RAM port to the CPU when toggled into run mode.
module prog_mem_ctrl
    import cpu_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE = DEF_DEBOUNCE,
    parameter logic [19:0] TIMEOUT  = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic [ADDR_W-1:0] addrPC,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mode,
    output logic [CNT_W-1:0]  words_loaded,
    output logic              full,
    output logic              err_timeout
);

    localparam logic [CNT_W-1:0] WORDS_MAX = 9'd256;

    state_t              state_reg, state_next;
    logic [7:0]          lo_reg, hi_reg;
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]    words_reg;
    logic                full_reg;
    logic                err_reg;
    logic [19:0]         tcnt_reg;
    logic                press;
    logic                timeout_hit;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_deb (
        .clk   (clk),
        .reset (reset),
        .btn_n (button),
        .press (press)
    );

    assign timeout_hit = (tcnt_reg == TIMEOUT - 20'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= LOAD_LO;
        else       state_reg <= state_next;
    end

    // A press always wins over a same-cycle byte; WRITE still issues its write first.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD_LO: begin
                if (press)                     state_next = RUN;
                else if (rx_valid && !full_reg) state_next = LOAD_HI;
            end
            LOAD_HI: begin
                if (press)            state_next = RUN;
                else if (rx_valid)    state_next = WRITE;
                else if (timeout_hit) state_next = LOAD_LO;
            end
            WRITE: begin
                if (press) state_next = RUN;
                else       state_next = LOAD_LO;
            end
            RUN: begin
                if (press) state_next = LOAD_LO;
            end
            default: state_next = LOAD_LO;
        endcase
    end

    always_comb begin
        mem_we    = (state_reg == WRITE);
        mode      = (state_reg == RUN);
        mem_addr  = (state_reg == RUN) ? addrPC : wr_ptr_reg;
        mem_wdata = {hi_reg, lo_reg};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo_reg     <= 8'd0;
            hi_reg     <= 8'd0;
            wr_ptr_reg <= '0;
            words_reg  <= '0;
            full_reg   <= 1'b0;
            err_reg    <= 1'b0;
            tcnt_reg   <= 20'd0;
        end else begin
            case (state_reg)
                LOAD_LO: begin
                    tcnt_reg <= 20'd0;
                    if (!press && rx_valid && !full_reg)
                        lo_reg <= rx_data;
                end
                LOAD_HI: begin
                    if (!press) begin
                        if (rx_valid)
                            hi_reg <= rx_data;
                        else if (timeout_hit)
                            err_reg <= 1'b1;
                        else
                            tcnt_reg <= tcnt_reg + 20'd1;
                    end
                end
                WRITE: begin
                    wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (words_reg != WORDS_MAX)
                        words_reg <= words_reg + 1'b1;
                    if (wr_ptr_reg == {ADDR_W{1'b1}})
                        full_reg <= 1'b1;
                end
                RUN: begin
                    if (press) begin
                        wr_ptr_reg <= '0;
                        words_reg  <= '0;
                        full_reg   <= 1'b0;
                        err_reg    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign words_loaded = words_reg;
    assign full         = full_reg;
    assign err_timeout  = err_reg;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Scoreboard bench for prog_mem_ctrl: expected writes are queued by the
// stimulus and matched by an independent monitor on every mem_we cycle.
module tb_prog_mem_ctrl;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        button;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  addrPC;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mode;
    logic [8:0]  words_loaded;
    logic        full;
    logic        err_timeout;

    wr_t exp_q[$];
    int  tests  = 0;
    int  fails  = 0;

    prog_mem_ctrl #(
        .DEBOUNCE (16'd5),
        .TIMEOUT  (20'd1000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button       (button),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .addrPC       (addrPC),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mode         (mode),
        .words_loaded (words_loaded),
        .full         (full),
        .err_timeout  (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_t e;
            tests++;
            if (mode !== 1'b0) begin
                fails++;
                $display("FAIL write_in_run: addr %0h data %0h while mode=1", mem_addr, mem_wdata);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    fails++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             mem_addr, mem_wdata, e.addr, e.data);
                end else begin
                    $display("[TB] write addr %0h data %0h", mem_addr, mem_wdata);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] lo, input logic [7:0] hi,
                             input bit expect_wr, input logic [7:0] addr);
        wr_t e;
        if (expect_wr) begin
            e.addr = addr;
            e.data = {hi, lo};
            exp_q.push_back(e);
        end
        send_byte(lo);
        send_byte(hi);
        @(posedge clk); #1;
    endtask

    // Button low for 10 cycles, then released long enough to re-arm.
    task automatic press_btn();
        @(posedge clk); #1;
        button = 1'b0;
        repeat (10) @(posedge clk);
        #1 button = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        button   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        addrPC   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_mode", {31'd0, mode}, 32'd0);
        check("rst_words", {23'd0, words_loaded}, 32'd0);
        check("rst_flags", {30'd0, full, err_timeout}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        send_word(8'h0B, 8'h13, 1'b1, 8'h00);
        send_word(8'h00, 8'h0E, 1'b1, 8'h01);
        check("words_after_2", {23'd0, words_loaded}, 32'd2);
        check("addr_after_2", {24'd0, mem_addr}, 32'd2);

        press_btn();
        check("mode_run", {31'd0, mode}, 32'd1);
        addrPC = 8'h01;
        #1 check("run_addr_pc", {24'd0, mem_addr}, 32'h01);
        addrPC = 8'hC7;
        #1 check("run_addr_pc2", {24'd0, mem_addr}, 32'hC7);
        send_word(8'hAA, 8'hBB, 1'b0, 8'h00);
        check("run_words_kept", {23'd0, words_loaded}, 32'd2);

        press_btn();
        check("load_mode", {31'd0, mode}, 32'd0);
        check("load_cleared", {23'd0, words_loaded}, 32'd0);
        check("load_addr0", {24'd0, mem_addr}, 32'd0);

        send_byte(8'h55);
        repeat (1005) @(posedge clk);
        #1;
        check("timeout_err", {31'd0, err_timeout}, 32'd1);
        check("timeout_nowr", {23'd0, words_loaded}, 32'd0);
        send_word(8'h34, 8'h12, 1'b1, 8'h00);
        check("err_sticky", {31'd0, err_timeout}, 32'd1);
        check("words_after_to", {23'd0, words_loaded}, 32'd1);

        for (int i = 1; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i);
            send_word(a, a ^ 8'hA5, 1'b1, a);
        end
        check("full_set", {31'd0, full}, 32'd1);
        check("words_256", {23'd0, words_loaded}, 32'd256);
        check("ptr_wrapped", {24'd0, mem_addr}, 32'd0);
        send_word(8'h99, 8'h88, 1'b0, 8'h00);
        check("words_sat", {23'd0, words_loaded}, 32'd256);

        press_btn();
        press_btn();
        check("full_cleared", {30'd0, full, err_timeout}, 32'd0);

        send_byte(8'h77);
        press_btn();
        check("press_lohi_run", {31'd0, mode}, 32'd1);
        press_btn();
        check("back_load", {31'd0, mode}, 32'd0);

        // Hi byte lands exactly on the press-pulse cycle: sync (2) + debounce (5) - 1 edges.
        send_byte(8'h66);
        @(posedge clk); #1;
        button = 1'b0;
        repeat (6) @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_data = 8'h44;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 button = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("coincident_run", {31'd0, mode}, 32'd1);
        check("coincident_nowr", {23'd0, words_loaded}, 32'd0);
        press_btn();

        send_word(8'h01, 8'h02, 1'b1, 8'h00);
        send_byte(8'hEE);
        reset = 1'b1;
        #1;
        check("midrst_we", {31'd0, mem_we}, 32'd0);
        check("midrst_addr", {24'd0, mem_addr}, 32'd0);
        check("midrst_wdata", {16'd0, mem_wdata}, 32'd0);
        check("midrst_words", {23'd0, words_loaded}, 32'd0);
        check("midrst_mode", {31'd0, mode}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        send_word(8'hCD, 8'hAB, 1'b1, 8'h00);
        check("post_rst_words", {23'd0, words_loaded}, 32'd1);

        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
